// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg
//   Shared definitions for the RV32M multiply/divide sequencer:
//   funct3 operation encodings, FSM state encodings, datapath width
//   constants and small decode helpers for operand signedness.
package mdu_sequencer_pkg;

  localparam int          MDU_N     = 32;
  localparam int          MDU_CNT_W = 5;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // funct3 of the RV32M instructions
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM. MUL only
  // returns the low word, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_a_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_b_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub
//   Combinational (N+1)-bit adder/subtractor shared by the multiply
//   (accumulate) and divide (trial subtract) iterations.
//   Ports:
//     i_a, i_b  (N+1) operands
//     i_sub     1 selects i_a - i_b, 0 selects i_a + i_b
//     o_sum     (N+1) result
//     o_co      carry out of the top bit; for subtraction 1 means no borrow
module mdu_addsub #(
  parameter int N = 32
) (
  input  logic [N:0] i_a,
  input  logic [N:0] i_b,
  input  logic       i_sub,
  output logic [N:0] o_sum,
  output logic       o_co
);

  logic [N:0] w_b_eff;

  assign w_b_eff       = i_sub ? ~i_b : i_b;
  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{(N + 1){1'b0}}, i_sub};

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Multi-cycle RV32M controller. Accepts one MUL/DIV/REM at a time and
//   runs a 32-step shift-add multiply or restoring divide over one shared
//   (N+1)-bit add/sub. busy stalls the pipeline until a registered result
//   is returned with a one-cycle done pulse. flush aborts the operation.
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-low reset
//     start    request, accepted only in IDLE
//     op       funct3 operation select
//     A, B     rs1 / rs2 operands
//     flush    abort the in-flight operation
//     busy     high in every state except IDLE
//     done     one-cycle result-valid pulse
//     Result   registered result, held until the next done
//     DivZero  registered with Result; DIV/REM had B == 0
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int N     = MDU_N,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result,
  output logic         DivZero
);

  localparam logic [N-1:0]     INT_MIN_N = {1'b1, {(N - 1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);

  state_e         r_state;
  state_e         w_state_next;
  mdu_op_e        r_op;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;          // raw rs2, then |rs2| (multiplicand / divisor)
  logic [N-1:0]   r_hi;         // product high word / remainder
  logic [N-1:0]   r_lo;         // product low word / quotient / preloaded result
  logic [CNT_W-1:0] r_cnt;
  logic           r_neg_q;      // negate product or quotient
  logic           r_neg_r;      // negate remainder
  logic           r_special;    // result preloaded in r_lo, CALC skipped
  logic [N-1:0]   r_result;
  logic           r_div_zero;

  logic           w_accept;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [N-1:0]   w_abs_a;
  logic [N-1:0]   w_abs_b;
  logic           w_b_zero;
  logic           w_ovf;
  logic           w_special;
  logic [N-1:0]   w_special_val;
  logic [N:0]     w_as_a;
  logic [N:0]     w_as_b;
  logic [N:0]     w_as_sum;
  logic           w_as_co;
  logic [N:0]     w_mul_hi;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quo;
  logic [N-1:0]   w_rem;
  logic [N-1:0]   w_fix_result;

  // flush in IDLE drops a simultaneous start.
  assign w_accept = start && !flush;

  // ---------------- PREP decode (operands are already latched) -------------
  assign w_a_neg  = op_a_signed(r_op) && r_a[N-1];
  assign w_b_neg  = op_b_signed(r_op) && r_b[N-1];
  assign w_abs_a  = w_a_neg ? -r_a : r_a;
  assign w_abs_b  = w_b_neg ? -r_b : r_b;
  assign w_b_zero = (r_b == '0);
  assign w_ovf    = (r_op inside {MDU_DIV, MDU_REM}) && (r_a == INT_MIN_N) && (r_b == '1);
  assign w_special = r_op[2] && (w_b_zero || w_ovf);

  // op[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    if (w_b_zero) w_special_val = r_op[1] ? r_a : '1;
    else          w_special_val = r_op[1] ? '0  : INT_MIN_N;
  end

  // ---------------- shared add/sub ------------------------------------------
  // Multiply: {0,hi} + {0,mcand}; the 33rd sum bit is the carry shifted in.
  // Divide:   {rem,quo[N-1]} - {0,divisor}; carry out means no borrow.
  assign w_as_a = r_op[2] ? {r_hi, r_lo[N-1]} : {1'b0, r_hi};
  assign w_as_b = {1'b0, r_b};

  mdu_addsub #(.N(N)) u_addsub (
    .i_a   (w_as_a),
    .i_b   (w_as_b),
    .i_sub (r_op[2]),
    .o_sum (w_as_sum),
    .o_co  (w_as_co)
  );

  assign w_mul_hi = r_lo[0] ? w_as_sum : {1'b0, r_hi};

  // ---------------- FIX result select ---------------------------------------
  assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_neg_q ? -r_lo : r_lo;
  assign w_rem  = r_neg_r ? -r_hi : r_hi;

  always_comb begin
    w_fix_result = r_lo;
    if (!r_special) begin
      unique case (r_op)
        MDU_MUL:                         w_fix_result = w_prod[N-1:0];
        MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_result = w_prod[2*N-1:N];
        MDU_DIV, MDU_DIVU:               w_fix_result = w_quo;
        MDU_REM, MDU_REMU:               w_fix_result = w_rem;
        default:                         w_fix_result = r_lo;
      endcase
    end
  end

  // ---------------- FSM next state / outputs --------------------------------
  // NOTE: every output of this block is given a default before the case so
  // no path leaves a value unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_next = S_PREP;
      end
      S_PREP: w_state_next = w_special ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == CNT_LAST) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_DONE;
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush && (r_state != S_IDLE)) w_state_next = S_IDLE;
  end

  // ---------------- state and datapath registers ----------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= MDU_MUL;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= mdu_op_e'(op);
            r_a  <= A;
            r_b  <= B;
          end
        end
        S_PREP: begin
          r_cnt     <= '0;
          r_hi      <= '0;
          r_lo      <= w_special ? w_special_val : w_abs_a;
          r_b       <= w_abs_b;
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_special <= w_special;
        end
        S_CALC: begin
          // The counter returns to 0 only through the exit compare.
          r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
          if (r_op[2]) begin
            r_hi <= w_as_co ? w_as_sum[N-1:0] : w_as_a[N-1:0];
            r_lo <= {r_lo[N-2:0], w_as_co};
          end else begin
            {r_hi, r_lo} <= {w_mul_hi, r_lo[N-1:1]};
          end
        end
        S_FIX: begin
          // A flush here must leave the previous result visible.
          if (!flush) begin
            r_result   <= w_fix_result;
            r_div_zero <= r_op[2] && (r_b == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign Result  = r_result;
  assign DivZero = r_div_zero;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int LAT_CALC = 35;  // N+3 edges after the drive cycle
  localparam int LAT_SPEC = 3;   // special cases skip CALC

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        DivZero;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  mdu_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .Result  (Result),
    .DivZero (DivZero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) n_done++;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request on a negedge and count rising edges until done is
  // seen. lat = 0 means no done within the budget. Returns in IDLE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic dz);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    lat = 0; res = 'x; dz = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k; res = Result; dz = DivZero;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic d, input int l);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.res = r; v.dz = d; v.lat = l;
    return v;
  endfunction

  initial begin
    int          lat;
    logic [31:0] res;
    logic        dz;
    int          done_before;
    logic [31:0] last_res;

    vecs.push_back(mk(MDU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MULH,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MULHU,  32'd7,        32'hFFFF_FFFD, 32'h0000_0006, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MULHSU, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_DIV,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_REM,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_DIVU,   32'd20,       32'd3,         32'd6,         1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_REMU,   32'd20,       32'd3,         32'd2,         1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_CALC));
    vecs.push_back(mk(MDU_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, 1'b1, LAT_SPEC));
    vecs.push_back(mk(MDU_REMU,   32'd5,        32'd0,         32'd5,         1'b1, LAT_SPEC));
    vecs.push_back(mk(MDU_REM,    32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 1'b1, LAT_SPEC));
    vecs.push_back(mk(MDU_DIVU,   32'd9,        32'd0,         32'hFFFF_FFFF, 1'b1, LAT_SPEC));
    vecs.push_back(mk(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_SPEC));
    vecs.push_back(mk(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0, LAT_SPEC));
    vecs.push_back(mk(MDU_MUL,    32'd12345,    32'd1000,      32'd12345000,  1'b0, LAT_CALC));

    // ---- power-on reset, start held high is ignored -------------------
    start = 1'b1; op = MDU_MUL; A = 32'd3; B = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",    {31'd0, busy},    32'd0);
    check("reset done",    {31'd0, done},    32'd0);
    check("reset Result",  Result,           32'd0);
    check("reset DivZero", {31'd0, DivZero}, 32'd0);
    @(negedge clk); rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle after reset busy", {31'd0, busy}, 32'd0);

    // ---- table-driven vectors -----------------------------------------
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, dz);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d Result", i), res, vecs[i].res);
      check($sformatf("vec%0d DivZero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      check($sformatf("vec%0d idle busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d Result held", i), Result, vecs[i].res);
    end
    last_res = vecs[vecs.size() - 1].res;

    // ---- flush mid-CALC: no done, Result unchanged --------------------
    done_before = n_done;
    @(negedge clk);
    start = 1'b1; op = MDU_MULHSU; A = 32'hFFFF_FFF0; B = 32'd77;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("busy before flush", {31'd0, busy}, 32'd1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy falls", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush no done", n_done - done_before, 0);
    check("flush Result kept", Result, last_res);
    check("flush DivZero kept", {31'd0, DivZero}, 32'd0);

    // New request right after the flush completes normally.
    run_op(MDU_MULHSU, 32'hFFFF_FFF0, 32'd77, lat, res, dz);
    check("post-flush latency", lat, LAT_CALC);
    check("post-flush Result", res, 32'hFFFF_FFFF);  // -16*77 = -1232, high word all ones

    // ---- flush in IDLE drops start ------------------------------------
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MDU_DIV; A = 32'd5; B = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle flush drops start", {31'd0, busy}, 32'd0);

    // ---- flush in FIX keeps Result and DivZero ------------------------
    done_before = n_done;
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; A = 32'd5; B = 32'd0;
    @(posedge clk); #1;             // PREP
    start = 1'b0;
    @(posedge clk); #1;             // FIX
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("FIX flush no done", n_done - done_before, 0);
    check("FIX flush Result kept", Result, 32'hFFFF_FFFF);  // from post-flush MULHSU
    check("FIX flush DivZero kept", {31'd0, DivZero}, 32'd0);

    // ---- start while busy: no second done -----------------------------
    done_before = n_done;
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; A = 32'd100; B = 32'd7;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
    end
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("busy start ignored", n_done - done_before, 1);
    check("busy start Result", Result, 32'd14);

    // ---- reset mid-CALC with start held -------------------------------
    @(negedge clk);
    start = 1'b1; op = MDU_MUL; A = 32'd9; B = 32'd9;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk); rst = 1'b0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("mid reset busy",    {31'd0, busy},    32'd0);
    check("mid reset done",    {31'd0, done},    32'd0);
    check("mid reset Result",  Result,           32'd0);
    check("mid reset DivZero", {31'd0, DivZero}, 32'd0);
    @(negedge clk); rst = 1'b1; start = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("after mid reset idle", {31'd0, busy}, 32'd0);

    run_op(MDU_MUL, 32'd9, 32'd9, lat, res, dz);
    check("post-reset latency", lat, LAT_CALC);
    check("post-reset Result", res, 32'd81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
